ex_mem_stage: RTL and testbench
===============================

EX_MEM_STAGE -- requirements
Module: ex_mem_stage
Interface
REQ-001 Ports SHALL be exactly as listed (name  direction  width  meaning); one clock clk; reset is synchronous and active-high:
clk  input  1  sole clock; all state updates on its rising edge
reset  input  1  synchronous, active-high
stall  input  1  hold the EX/MEM register (downstream not ready)
flush  input  1  load a bubble into the EX/MEM register
PCSrc  input  3  from ID/EX; 3'b001 = conditional branch
RegDst  input  2  00 Rd, 01 Rt, 10 r31, 11 r26
RegWr  input  1  write-back enable
ALUSrc1  input  1  1: operand A = zero-extended Shamt
ALUSrc2  input  1  1: operand B = Extend
ALUFun  input  6  ALU operation code
Sign  input  1  1: signed compare
MemWr  input  1  store
MemRd  input  1  load
MemToReg  input  2  00 ALU, 01 memory, 10 link (NextPC)
Extend  input  32  extended immediate
Rs  input  5  source A index
Rt  input  5  source B index
Rd  input  5  destination index
Shamt  input  5  shift amount
ReadData1  input  32  register-file value A
ReadData2  input  32  register-file value B
NextPC  input  32  PC+4 of the instruction
WB_RegWr  input  1  MEM/WB write enable (forwarding)
WB_WriteReg  input  5  MEM/WB destination index
WB_Data  input  32  MEM/WB write data
BranchTaken  output  1  combinational branch resolution
BranchTarget  output  32  combinational NextPC + (Extend<<2)
oRegWr  output  1  registered write-back enable
oMemWr  output  1  registered store enable
oMemRd  output  1  registered load enable
oMemToReg  output  2  registered write-back select
oALUOut  output  32  registered result (address or data)
oWriteData  output  32  registered store data (forwarded B)
oWriteReg  output  5  registered resolved destination index
Function
REQ-002 Operand A SHALL be ALUSrc1 ? {27'b0,Shamt} : fwdA, and operand B SHALL be ALUSrc2 ? Extend : fwdB; fwdA and fwdB are defined by REQ-009/REQ-010.
REQ-003 ALU SHALL decode ALUFun as follows:
- Arithmetic/logic: ADD 000000, SUB 000001, AND 011000, OR 011110, XOR 010110, NOR 010001.
- Shifts: SLL 100000, SRL 100001, SRA 100011; shifts SHALL shift B by A[4:0].
- Compares: EQ 110011, NEQ 110001, LT 110101, LEZ 111101, LTZ 111011, GTZ 111111; compares SHALL yield 32'd1 or 32'd0.
- LT SHALL be signed when Sign=1 and unsigned when Sign=0.
- Add/sub SHALL wrap modulo 2^32 with no trap; undefined codes SHALL yield 0.
REQ-004 Result SHALL be NextPC when MemToReg==2'b10, else the ALU output; WriteReg SHALL be resolved from RegDst; WriteData SHALL be fwdB.
REQ-005 BranchTaken SHALL equal (PCSrc==3'b001) && ALU[0], combinational in the same cycle; BranchTarget SHALL be a 32-bit wrap-around add.
REQ-006 EX/MEM register update on each rising edge, priority reset > flush > stall > capture:
- flush SHALL zero all registered outputs.
- stall SHALL hold all registered outputs.
- Otherwise the register SHALL capture the current results, giving a latency of exactly one cycle.
REQ-007 oRegWr SHALL be captured as 0 whenever the resolved WriteReg is 0.
Reset
REQ-008 reset high at a rising edge SHALL zero every registered output, overriding flush and stall, including mid-stall; combinational outputs SHALL track their inputs during reset.
Configuration
REQ-009 With FORWARD_EN defined:
- fwdA SHALL be oALUOut if oRegWr && oMemToReg!=2'b01 && oWriteReg==Rs && Rs!=0.
- Else fwdA SHALL be WB_Data if WB_RegWr && WB_WriteReg==Rs && Rs!=0.
- Else fwdA SHALL be ReadData1.
- fwdB SHALL follow the same rules using Rt and ReadData2; EX/MEM SHALL take priority over WB.
REQ-010 With FORWARD_EN undefined, fwdA SHALL be ReadData1 and fwdB SHALL be ReadData2; the WB_* ports SHALL remain present and be ignored.
Verification
REQ-011 ADD, ReadData1=5, ReadData2=7, RegDst=00, Rd=3, RegWr=1 -> after one edge oALUOut=12, oWriteReg=3, oRegWr=1; the same instruction with Rd=0 -> oRegWr=0.
REQ-012 Instruction 1 writes r3=12, then instruction 2 is ADD with Rs=3, ReadData1=0, ReadData2=1 -> oALUOut=13 with FORWARD_EN, 1 without; WB_WriteReg=4, WB_Data=9 and Rt=4 with no EX/MEM match -> operand B=9.
REQ-013 stall=1 for two edges while inputs change -> all registered outputs unchanged; stall=1 and flush=1 together -> all registered outputs 0.
REQ-014 PCSrc=001, EQ, ReadData1=ReadData2=9, NextPC=0x100, Extend=0xFFFFFFFF -> BranchTaken=1, BranchTarget=0x000000FC; reset asserted at the same edge as a valid capture -> all registered outputs 0.

Source files
------------

// File: rtl/ex_mem_stage.sv
// ex_mem_stage
//   Execute stage of a five-stage MIPS-style pipeline, followed by the EX/MEM
//   pipeline register.
//   - Operand selection: shamt or forwarded A, immediate or forwarded B.
//   - 32-bit ALU: add/sub, logic ops, shifts and compares.
//   - Combinational branch resolution (BranchTaken / BranchTarget).
//   - EX/MEM register. Update priority on each edge is
//     reset > flush > stall > capture.
//
// Optional feature
//   FORWARD_EN: when defined, operands are forwarded from the EX/MEM register
//   and from the MEM/WB write port. EX/MEM has priority over MEM/WB.
//   When undefined, the WB_* inputs are present but ignored.
//
// Ports
//   clk, reset            : clock and synchronous active-high reset
//   stall, flush          : hold / bubble the EX/MEM register
//   PCSrc .. MemToReg     : ID/EX control fields
//   Extend, Rs, Rt, Rd,
//   Shamt                 : ID/EX instruction fields
//   ReadData1/2, NextPC   : ID/EX data
//   WB_RegWr, WB_WriteReg,
//   WB_Data               : MEM/WB write port, used for forwarding
//   BranchTaken,
//   BranchTarget          : combinational branch outputs
//   oRegWr .. oWriteReg   : registered EX/MEM outputs
module ex_mem_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic [2:0]  PCSrc,
  input  logic [1:0]  RegDst,
  input  logic        RegWr,
  input  logic        ALUSrc1,
  input  logic        ALUSrc2,
  input  logic [5:0]  ALUFun,
  input  logic        Sign,
  input  logic        MemWr,
  input  logic        MemRd,
  input  logic [1:0]  MemToReg,
  input  logic [31:0] Extend,
  input  logic [4:0]  Rs,
  input  logic [4:0]  Rt,
  input  logic [4:0]  Rd,
  input  logic [4:0]  Shamt,
  input  logic [31:0] ReadData1,
  input  logic [31:0] ReadData2,
  input  logic [31:0] NextPC,
  input  logic        WB_RegWr,
  input  logic [4:0]  WB_WriteReg,
  input  logic [31:0] WB_Data,
  output logic        BranchTaken,
  output logic [31:0] BranchTarget,
  output logic        oRegWr,
  output logic        oMemWr,
  output logic        oMemRd,
  output logic [1:0]  oMemToReg,
  output logic [31:0] oALUOut,
  output logic [31:0] oWriteData,
  output logic [4:0]  oWriteReg
);

  localparam logic [5:0] FN_ADD = 6'b000000;
  localparam logic [5:0] FN_SUB = 6'b000001;
  localparam logic [5:0] FN_AND = 6'b011000;
  localparam logic [5:0] FN_OR  = 6'b011110;
  localparam logic [5:0] FN_XOR = 6'b010110;
  localparam logic [5:0] FN_NOR = 6'b010001;
  localparam logic [5:0] FN_SLL = 6'b100000;
  localparam logic [5:0] FN_SRL = 6'b100001;
  localparam logic [5:0] FN_SRA = 6'b100011;
  localparam logic [5:0] FN_EQ  = 6'b110011;
  localparam logic [5:0] FN_NEQ = 6'b110001;
  localparam logic [5:0] FN_LT  = 6'b110101;
  localparam logic [5:0] FN_LEZ = 6'b111101;
  localparam logic [5:0] FN_LTZ = 6'b111011;
  localparam logic [5:0] FN_GTZ = 6'b111111;

  logic [31:0] fwd_a;
  logic [31:0] fwd_b;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [31:0] alu_out;
  logic [31:0] result;
  logic [4:0]  write_reg;
  logic        lt_flag;

  // EX/MEM register state
  logic        reg_wr_q,     reg_wr_d;
  logic        mem_wr_q,     mem_wr_d;
  logic        mem_rd_q,     mem_rd_d;
  logic [1:0]  mem_to_reg_q, mem_to_reg_d;
  logic [31:0] alu_out_q,    alu_out_d;
  logic [31:0] write_data_q, write_data_d;
  logic [4:0]  write_reg_q,  write_reg_d;

`ifdef FORWARD_EN
  // A load in EX/MEM has no data yet (oALUOut is only its address), so it
  // is not a forwarding source. Register 0 is never forwarded.
  always_comb begin
    fwd_a = ReadData1;
    if (reg_wr_q && (mem_to_reg_q != 2'b01) && (write_reg_q == Rs) && (Rs != 5'd0))
      fwd_a = alu_out_q;
    else if (WB_RegWr && (WB_WriteReg == Rs) && (Rs != 5'd0))
      fwd_a = WB_Data;

    fwd_b = ReadData2;
    if (reg_wr_q && (mem_to_reg_q != 2'b01) && (write_reg_q == Rt) && (Rt != 5'd0))
      fwd_b = alu_out_q;
    else if (WB_RegWr && (WB_WriteReg == Rt) && (Rt != 5'd0))
      fwd_b = WB_Data;
  end
`else
  logic unused_fwd_inputs;
  assign unused_fwd_inputs = ^{WB_RegWr, WB_WriteReg, WB_Data, Rs};
  assign fwd_a = ReadData1;
  assign fwd_b = ReadData2;
`endif

  assign op_a = ALUSrc1 ? {27'b0, Shamt} : fwd_a;
  assign op_b = ALUSrc2 ? Extend : fwd_b;

  assign lt_flag = Sign ? ($signed(op_a) < $signed(op_b)) : (op_a < op_b);

  // The LEZ/LTZ/GTZ compares test operand A against zero as a signed value.
  always_comb begin
    alu_out = 32'd0;
    case (ALUFun)
      FN_ADD: alu_out = op_a + op_b;
      FN_SUB: alu_out = op_a - op_b;
      FN_AND: alu_out = op_a & op_b;
      FN_OR:  alu_out = op_a | op_b;
      FN_XOR: alu_out = op_a ^ op_b;
      FN_NOR: alu_out = ~(op_a | op_b);
      FN_SLL: alu_out = op_b << op_a[4:0];
      FN_SRL: alu_out = op_b >> op_a[4:0];
      FN_SRA: alu_out = $signed(op_b) >>> op_a[4:0];
      FN_EQ:  alu_out = {31'b0, (op_a == op_b)};
      FN_NEQ: alu_out = {31'b0, (op_a != op_b)};
      FN_LT:  alu_out = {31'b0, lt_flag};
      FN_LEZ: alu_out = {31'b0, (op_a[31] || (op_a == 32'd0))};
      FN_LTZ: alu_out = {31'b0, op_a[31]};
      FN_GTZ: alu_out = {31'b0, (!op_a[31] && (op_a != 32'd0))};
      default: alu_out = 32'd0;
    endcase
  end

  assign BranchTaken  = (PCSrc == 3'b001) && alu_out[0];
  assign BranchTarget = NextPC + {Extend[29:0], 2'b00};

  assign result = (MemToReg == 2'b10) ? NextPC : alu_out;

  always_comb begin
    write_reg = Rd;
    case (RegDst)
      2'b00:   write_reg = Rd;
      2'b01:   write_reg = Rt;
      2'b10:   write_reg = 5'd31;
      default: write_reg = 5'd26;
    endcase
  end

  // flush > stall > capture; reset is applied in the flop block.
  always_comb begin
    reg_wr_d     = reg_wr_q;
    mem_wr_d     = mem_wr_q;
    mem_rd_d     = mem_rd_q;
    mem_to_reg_d = mem_to_reg_q;
    alu_out_d    = alu_out_q;
    write_data_d = write_data_q;
    write_reg_d  = write_reg_q;
    if (flush) begin
      reg_wr_d     = 1'b0;
      mem_wr_d     = 1'b0;
      mem_rd_d     = 1'b0;
      mem_to_reg_d = 2'b00;
      alu_out_d    = 32'd0;
      write_data_d = 32'd0;
      write_reg_d  = 5'd0;
    end else if (!stall) begin
      // Writes to r0 are dropped here so later stages never see them.
      reg_wr_d     = RegWr && (write_reg != 5'd0);
      mem_wr_d     = MemWr;
      mem_rd_d     = MemRd;
      mem_to_reg_d = MemToReg;
      alu_out_d    = result;
      write_data_d = fwd_b;
      write_reg_d  = write_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      reg_wr_q     <= 1'b0;
      mem_wr_q     <= 1'b0;
      mem_rd_q     <= 1'b0;
      mem_to_reg_q <= 2'b00;
      alu_out_q    <= 32'd0;
      write_data_q <= 32'd0;
      write_reg_q  <= 5'd0;
    end else begin
      reg_wr_q     <= reg_wr_d;
      mem_wr_q     <= mem_wr_d;
      mem_rd_q     <= mem_rd_d;
      mem_to_reg_q <= mem_to_reg_d;
      alu_out_q    <= alu_out_d;
      write_data_q <= write_data_d;
      write_reg_q  <= write_reg_d;
    end
  end

  assign oRegWr     = reg_wr_q;
  assign oMemWr     = mem_wr_q;
  assign oMemRd     = mem_rd_q;
  assign oMemToReg  = mem_to_reg_q;
  assign oALUOut    = alu_out_q;
  assign oWriteData = write_data_q;
  assign oWriteReg  = write_reg_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// tb_ex_mem_stage
//   Directed cases plus randomized stimulus for ex_mem_stage, checked
//   against a behavioural model of the execute stage and the EX/MEM register.
//   Inputs change just after the falling edge. Combinational outputs are
//   sampled 1 time unit later, and registered outputs 1 time unit after the
//   rising edge.
module tb_ex_mem_stage;

  logic        clk;
  logic        reset, stall, flush;
  logic [2:0]  PCSrc;
  logic [1:0]  RegDst;
  logic        RegWr, ALUSrc1, ALUSrc2;
  logic [5:0]  ALUFun;
  logic        Sign, MemWr, MemRd;
  logic [1:0]  MemToReg;
  logic [31:0] Extend;
  logic [4:0]  Rs, Rt, Rd, Shamt;
  logic [31:0] ReadData1, ReadData2, NextPC;
  logic        WB_RegWr;
  logic [4:0]  WB_WriteReg;
  logic [31:0] WB_Data;
  logic        BranchTaken;
  logic [31:0] BranchTarget;
  logic        oRegWr, oMemWr, oMemRd;
  logic [1:0]  oMemToReg;
  logic [31:0] oALUOut, oWriteData;
  logic [4:0]  oWriteReg;

  ex_mem_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .PCSrc(PCSrc), .RegDst(RegDst), .RegWr(RegWr), .ALUSrc1(ALUSrc1),
    .ALUSrc2(ALUSrc2), .ALUFun(ALUFun), .Sign(Sign), .MemWr(MemWr),
    .MemRd(MemRd), .MemToReg(MemToReg), .Extend(Extend), .Rs(Rs), .Rt(Rt),
    .Rd(Rd), .Shamt(Shamt), .ReadData1(ReadData1), .ReadData2(ReadData2),
    .NextPC(NextPC), .WB_RegWr(WB_RegWr), .WB_WriteReg(WB_WriteReg),
    .WB_Data(WB_Data), .BranchTaken(BranchTaken), .BranchTarget(BranchTarget),
    .oRegWr(oRegWr), .oMemWr(oMemWr), .oMemRd(oMemRd), .oMemToReg(oMemToReg),
    .oALUOut(oALUOut), .oWriteData(oWriteData), .oWriteReg(oWriteReg)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_q[$];

  // Expected contents of the EX/MEM register
  logic        m_regwr, m_memwr, m_memrd;
  logic [1:0]  m_m2r;
  logic [31:0] m_alu, m_wdata;
  logic [4:0]  m_wreg;

  logic [5:0] fun_tab [15] = '{6'b000000, 6'b000001, 6'b011000, 6'b011110,
                               6'b010110, 6'b010001, 6'b100000, 6'b100001,
                               6'b100011, 6'b110011, 6'b110001, 6'b110101,
                               6'b111101, 6'b111011, 6'b111111};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_alu(input logic [5:0] fun, input logic [31:0] a,
                                          input logic [31:0] b, input logic sgn);
    int signed sa, sb;
    sa = a;
    sb = b;
    case (fun)
      6'b000000: return a + b;
      6'b000001: return a - b;
      6'b011000: return a & b;
      6'b011110: return a | b;
      6'b010110: return a ^ b;
      6'b010001: return ~(a | b);
      6'b100000: return b << a[4:0];
      6'b100001: return b >> a[4:0];
      6'b100011: return sb >>> a[4:0];
      6'b110011: return (a == b) ? 32'd1 : 32'd0;
      6'b110001: return (a != b) ? 32'd1 : 32'd0;
      6'b110101: return (sgn ? (sa < sb) : (a < b)) ? 32'd1 : 32'd0;
      6'b111101: return (sa <= 0) ? 32'd1 : 32'd0;
      6'b111011: return (sa < 0) ? 32'd1 : 32'd0;
      6'b111111: return (sa > 0) ? 32'd1 : 32'd0;
      default:   return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] ref_fwd(input logic [4:0] idx, input logic [31:0] rd);
`ifdef FORWARD_EN
    if (idx != 0 && m_regwr && m_m2r != 2'b01 && m_wreg == idx) return m_alu;
    if (idx != 0 && WB_RegWr && WB_WriteReg == idx) return WB_Data;
`endif
    return rd;
  endfunction

  // One pipeline cycle: check the combinational outputs, clock, update the
  // model, then check the registered outputs.
  task automatic step();
    logic [31:0] a, b, alu, res, fb;
    logic [4:0]  wr;
    #1;
    fb  = ref_fwd(Rt, ReadData2);
    a   = ALUSrc1 ? 32'(Shamt) : ref_fwd(Rs, ReadData1);
    b   = ALUSrc2 ? Extend : fb;
    alu = ref_alu(ALUFun, a, b, Sign);
    check("branch_taken", 32'(BranchTaken), 32'((PCSrc == 3'b001) && alu[0]));
    check("branch_target", BranchTarget, NextPC + Extend * 4);
    res = (MemToReg == 2'b10) ? NextPC : alu;
    wr  = (RegDst == 2'd0) ? Rd : (RegDst == 2'd1) ? Rt : (RegDst == 2'd2) ? 5'd31 : 5'd26;
    @(posedge clk);
    if (reset || flush) begin
      {m_regwr, m_memwr, m_memrd, m_m2r, m_alu, m_wdata, m_wreg} = '0;
    end else if (!stall) begin
      m_regwr = RegWr && (wr != 0);
      m_memwr = MemWr;
      m_memrd = MemRd;
      m_m2r   = MemToReg;
      m_alu   = res;
      m_wdata = fb;
      m_wreg  = wr;
    end
    exp_q.push_back(m_alu);
    #1;
    check("oALUOut", oALUOut, exp_q.pop_front());
    check("oRegWr", 32'(oRegWr), 32'(m_regwr));
    check("oMemWr", 32'(oMemWr), 32'(m_memwr));
    check("oMemRd", 32'(oMemRd), 32'(m_memrd));
    check("oMemToReg", 32'(oMemToReg), 32'(m_m2r));
    check("oWriteData", oWriteData, m_wdata);
    check("oWriteReg", 32'(oWriteReg), 32'(m_wreg));
    @(negedge clk);
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_nop();
    {reset, stall, flush, RegWr, ALUSrc1, ALUSrc2, Sign, MemWr, MemRd, WB_RegWr} = '0;
    PCSrc = 3'd0; RegDst = 2'd0; ALUFun = 6'd0; MemToReg = 2'd0;
    Extend = 32'd0; Rs = 5'd0; Rt = 5'd0; Rd = 5'd0; Shamt = 5'd0;
    ReadData1 = 32'd0; ReadData2 = 32'd0; NextPC = 32'd0;
    WB_WriteReg = 5'd0; WB_Data = 32'd0;
  endtask

  task automatic set_add(input logic [31:0] d1, input logic [31:0] d2, input logic [4:0] rd);
    set_nop();
    ReadData1 = d1; ReadData2 = d2; Rd = rd; RegWr = 1'b1; ALUFun = 6'b000000;
  endtask

  task automatic drive_random();
    reset    = ($urandom_range(0, 19) == 0);
    flush    = ($urandom_range(0, 11) == 0);
    stall    = ($urandom_range(0, 5) == 0);
    PCSrc    = ($urandom_range(0, 1) == 0) ? 3'b001 : 3'($urandom);
    RegDst   = 2'($urandom);
    RegWr    = 1'($urandom);
    ALUSrc1  = ($urandom_range(0, 4) == 0);
    ALUSrc2  = ($urandom_range(0, 3) == 0);
    ALUFun   = ($urandom_range(0, 9) == 0) ? 6'($urandom) : fun_tab[$urandom_range(0, 14)];
    Sign     = 1'($urandom);
    MemWr    = 1'($urandom);
    MemRd    = 1'($urandom);
    MemToReg = 2'($urandom);
    Extend   = ($urandom_range(0, 1) == 0) ? 32'($signed(16'($urandom))) : $urandom;
    Rs       = 5'($urandom_range(0, 7));
    Rt       = 5'($urandom_range(0, 7));
    Rd       = 5'($urandom_range(0, 7));
    Shamt    = 5'($urandom);
    ReadData1 = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
    ReadData2 = ($urandom_range(0, 3) == 0) ? ReadData1 : $urandom;
    NextPC   = {$urandom_range(0, 32'h3fff_ffff), 2'b00};
    WB_RegWr = 1'($urandom);
    WB_WriteReg = 5'($urandom_range(0, 7));
    WB_Data  = $urandom;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] held_alu, held_wd;
    logic [4:0]  held_wr;
    logic        held_rw;
    {m_regwr, m_memwr, m_memrd, m_m2r, m_alu, m_wdata, m_wreg} = '0;

    // Reset with random inputs: registered outputs must come up zero.
    @(negedge clk);
    drive_random(); reset = 1'b1; step();
    check("reset_alu", oALUOut, 32'd0);
    check("reset_regwr", 32'(oRegWr), 32'd0);

    // Basic ADD, then the same with Rd=0.
    set_add(32'd5, 32'd7, 5'd3); step();
    check("add_alu", oALUOut, 32'd12);
    check("add_wreg", 32'(oWriteReg), 32'd3);
    check("add_regwr", 32'(oRegWr), 32'd1);
    set_add(32'd5, 32'd7, 5'd0); step();
    check("add_r0_regwr", 32'(oRegWr), 32'd0);

    // EX/MEM forwarding on A.
    set_add(32'd5, 32'd7, 5'd3); step();
    set_add(32'd0, 32'd1, 5'd6); Rs = 5'd3; Rt = 5'd5; step();
`ifdef FORWARD_EN
    check("fwd_exmem_a", oALUOut, 32'd13);
`else
    check("fwd_exmem_a", oALUOut, 32'd1);
`endif

    // MEM/WB forwarding on B (EX/MEM holds r6, no match on Rt=4).
    set_add(32'd0, 32'd2, 5'd7); Rt = 5'd4;
    WB_RegWr = 1'b1; WB_WriteReg = 5'd4; WB_Data = 32'd9; step();
`ifdef FORWARD_EN
    check("fwd_wb_b", oWriteData, 32'd9);
`else
    check("fwd_wb_b", oWriteData, 32'd2);
`endif

    // Stall for two edges while inputs change, then stall+flush.
    held_alu = oALUOut; held_wd = oWriteData; held_wr = oWriteReg; held_rw = oRegWr;
    for (int i = 0; i < 2; i++) begin
      drive_random(); reset = 1'b0; flush = 1'b0; stall = 1'b1; step();
    end
    check("stall_alu", oALUOut, held_alu);
    check("stall_wdata", oWriteData, held_wd);
    check("stall_wreg", 32'(oWriteReg), 32'(held_wr));
    check("stall_regwr", 32'(oRegWr), 32'(held_rw));
    drive_random(); reset = 1'b0; stall = 1'b1; flush = 1'b1; step();
    check("flush_alu", oALUOut, 32'd0);
    check("flush_wreg", 32'(oWriteReg), 32'd0);

    // Taken branch with negative offset, then reset over a valid capture.
    set_nop(); PCSrc = 3'b001; ALUFun = 6'b110011;
    ReadData1 = 32'd9; ReadData2 = 32'd9; NextPC = 32'h100; Extend = 32'hffff_ffff;
    #1;
    check("br_taken", 32'(BranchTaken), 32'd1);
    check("br_target", BranchTarget, 32'h0000_00fc);
    step();
    set_add(32'd5, 32'd7, 5'd3); MemWr = 1'b1; reset = 1'b1; step();
    check("reset_cap_alu", oALUOut, 32'd0);
    check("reset_cap_memwr", 32'(oMemWr), 32'd0);

    // Reset in the middle of a stall.
    set_add(32'd1, 32'd2, 5'd4); step();
    drive_random(); stall = 1'b1; reset = 1'b1; step();
    check("reset_stall_alu", oALUOut, 32'd0);

    // Randomized run against the model.
    for (int i = 0; i < 600; i++) begin
      drive_random();
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
